rca_chain_seq: RTL and testbench

- Multi-cycle add/subtract sequencer that time-shares one 16-bit ripple-carry adder slice (rca) across a wide operand.
- Each accepted operation processes one 16-bit chunk per cycle, LSB chunk first.
- Carry is registered between chunks; flags are produced from the final chunk.
- Sits between the ALU issue logic and the result writeback, using a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 9 +
 rtl/rca_chain_seq_if.sv | 29 ++
 rtl/rca_chain_seq_rca.sv | 25 ++
 rtl/rca_chain_seq.sv | 108 ++++++++++
 tb/tb_rca_chain_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: chunk width, sequencer state encoding and op codes.
package alu_pkg;
  localparam int CHUNK_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rca_chain_seq_if.sv
// Issue/writeback bundle for the chunked add/subtract sequencer.
interface rca_chain_seq_if #(parameter int WORDS = 4);
  import alu_pkg::*;
  localparam int W = CHUNK_W * WORDS;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds payload and valid stable until it does.
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/rca_chain_seq_rca.sv
// 16-bit ripple-carry adder slice; also exposes the carry into the MSB for overflow.
module rca
  import alu_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout,
  output logic               msbcin
);
  logic c;

  always_comb begin
    c      = cin;
    sum    = '0;
    msbcin = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      if (i == CHUNK_W - 1) msbcin = c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/rca_chain_seq.sv
// Add/subtract sequencer running one 16-bit rca slice over WORDS chunks, LSB first.
// Optional RCA_CHAIN_SEQ_SAT_EN: saturate the result on signed overflow.
module rca_chain_seq
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst_n,
  rca_chain_seq_if.slave bus,
  output state_t dbg_state
);
  localparam int W  = CHUNK_W * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q, result_q, res_nxt;
  logic          cy_q, carry_q, ovf_q, zero_q;
  logic [CHUNK_W-1:0] a_chunk, b_chunk, sum;
  logic          cout, msbcin, last, ovf_nxt;

  // b_q already holds ~B for subtract, so the slice only ever adds.
  assign a_chunk = a_q[cnt_q*CHUNK_W +: CHUNK_W];
  assign b_chunk = b_q[cnt_q*CHUNK_W +: CHUNK_W];
  assign last    = (state_q == RUN) && (cnt_q == LAST);

  rca u_rca (
    .a      (a_chunk),
    .b      (b_chunk),
    .cin    (cy_q),
    .sum    (sum),
    .cout   (cout),
    .msbcin (msbcin)
  );

  always_comb begin
    res_nxt = result_q;
    res_nxt[cnt_q*CHUNK_W +: CHUNK_W] = sum;
    ovf_nxt = msbcin ^ cout;
`ifdef RCA_CHAIN_SEQ_SAT_EN
    // Both operand signs clear means the true result is positive.
    if (last && ovf_nxt) begin
      res_nxt = (!a_q[W-1] && !b_q[W-1]) ? {1'b0, {(W-1){1'b1}}}
                                         : {1'b1, {(W-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = RUN;
      RUN:     if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.a;
          b_q   <= bus.b ^ {W{bus.op_sub}};
          cy_q  <= bus.op_sub;
          cnt_q <= '0;
        end
        RUN: begin
          result_q <= res_nxt;
          cy_q     <= cout;
          if (last) begin
            carry_q <= cout;
            ovf_q   <= ovf_nxt;
            zero_q  <= (res_nxt == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: if (bus.out_ready) cnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_rca_chain_seq.sv
// Scoreboard bench for rca_chain_seq (WORDS=4): directed vectors, reset, backpressure, back-to-back.
module tb_rca_chain_seq;
  import alu_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = 64;
  localparam int NV    = 9;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     out_idx  = 0;

  rca_chain_seq_if #(.WORDS(WORDS)) bus();

  rca_chain_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // directed vectors with hand-computed results
  logic         vop [NV];
  logic [W-1:0] va [NV], vb [NV], vr [NV];
  logic         vc [NV], vo [NV], vz [NV];

  logic [W+2:0] exp_q[$];
  logic [W+2:0] e;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_vec(input int i, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic c, input logic o, input logic z);
    vop[i] = op; va[i] = a; vb[i] = b; vr[i] = r; vc[i] = c; vo[i] = o; vz[i] = z;
  endtask

  // driver: present vector i, wait (bounded) for acceptance
  task automatic issue(input int i, input bit push, output int acc);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_sub   = vop[i];
    bus.a        = va[i];
    bus.b        = vb[i];
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: vector %0d not accepted within %0d cycles", i, n);
      acc = -1;
    end else begin
      if (push) exp_q.push_back({vr[i], vc[i], vo[i], vz[i]});
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.out_valid) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results still pending, out_valid=%b", exp_q.size(), bus.out_valid);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: result %h with nothing expected", bus.result);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("result[%0d]", out_idx),   bus.result,   e[W+2:3]);
        chk($sformatf("carry[%0d]", out_idx),    bus.carry,    e[2]);
        chk($sformatf("overflow[%0d]", out_idx), bus.overflow, e[1]);
        chk($sformatf("zero[%0d]", out_idx),     bus.zero,     e[0]);
      end
      out_idx++;
    end
  end

  initial begin
    int acc, prev, lat;

    set_vec(0, OP_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0, 0, 0);
    set_vec(1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0, 1);
`ifdef RCA_CHAIN_SEQ_SAT_EN
    set_vec(2, OP_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0000, 1, 1, 0);
    set_vec(3, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0);
    set_vec(8, OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 0);
`else
    set_vec(2, OP_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
    set_vec(3, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 1, 0);
    set_vec(8, OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1, 1, 1);
`endif
    set_vec(4, OP_SUB, 64'h5, 64'h5, 64'h0, 1, 0, 1);
    set_vec(5, OP_SUB, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    set_vec(6, OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 64'h2345_6789_ABCD_F001, 0, 0, 0);
    set_vec(7, OP_SUB, 64'h0001_0000_0000_0000, 64'h1, 64'h0000_FFFF_FFFF_FFFF, 1, 0, 0);

    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result",    bus.result,    0);
    chk("rst_flags",     {bus.carry, bus.overflow, bus.zero}, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_state",    dbg_state, IDLE);

    // latency: accept edge k -> out_valid after edge k+4
    bus.out_ready = 1'b1;
    issue(0, 1, acc);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, WORDS);
    wait_drain();

    issue(1, 1, acc);
    bus.in_valid = 1'b0;
    wait_drain();
    issue(2, 1, acc);
    bus.in_valid = 1'b0;
    wait_drain();

    // reset mid-RUN abandons the op
    issue(5, 0, acc);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_result",    bus.result,    0);
    chk("midrst_state",     dbg_state,     IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(5, 1, acc);
    bus.in_valid = 1'b0;
    wait_drain();

    // backpressure in DONE with a competing request held
    bus.out_ready = 1'b0;
    issue(3, 1, acc);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b1;
    bus.op_sub   = vop[7];
    bus.a        = va[7];
    bus.b        = vb[7];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_out_valid[%0d]", k), bus.out_valid, 1);
      chk($sformatf("bp_in_ready[%0d]", k),  bus.in_ready,  0);
      chk($sformatf("bp_result[%0d]", k),    bus.result,    vr[3]);
      chk($sformatf("bp_flags[%0d]", k), {bus.carry, bus.overflow, bus.zero}, {vc[3], vo[3], vz[3]});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    issue(7, 1, acc);
    bus.in_valid = 1'b0;
    wait_drain();

    // back-to-back with in_valid and out_ready held high
    prev = 0;
    for (int i = 0; i < NV; i++) begin
      issue(i, 1, acc);
      if (i > 0) chk($sformatf("issue_interval[%0d]", i), acc - prev, WORDS + 2);
      prev = acc;
    end
    bus.in_valid = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
